// File: rtl/rr_arb_2to1_8bits_pkg.sv
// Shared types and constants for the 2:1 round-robin merge arbiter.
package rr_arb_2to1_8bits_pkg;

    // Output register occupancy: EMPTY means OUT holds nothing deliverable.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Default payload width.
    localparam int DEF_DATA_W = 8;

    // Channel indices, matching the downstream 2:1 mux select encoding.
    localparam logic CH_IN1 = 1'b0;
    localparam logic CH_IN2 = 1'b1;

endpackage

// File: rtl/rr_grant_2.sv
// Two-requester round-robin grant. PRI holds the index of the last granted
// channel; on contention the other channel wins. EN gates both grants.
module rr_grant_2
    import rr_arb_2to1_8bits_pkg::*;
(
    input  logic VALID1,
    input  logic VALID2,
    input  logic PRI,
    input  logic EN,
    output logic GNT1,
    output logic GNT2
);

    // IN1 wins when alone, or on contention when IN2 was granted last.
    always_comb begin
        GNT1 = 1'b0;
        GNT2 = 1'b0;
        if (EN) begin
            if (VALID1 && VALID2) begin
                GNT1 = (PRI == CH_IN2);
                GNT2 = (PRI == CH_IN1);
            end else begin
                GNT1 = VALID1;
                GNT2 = VALID2;
            end
        end
    end

endmodule

// File: rtl/rr_arb_2to1_8bits.sv
// 2:1 round-robin merge of two valid/ready channels into one registered
// output stage. One beat of storage; sustains one beat per cycle when the
// consumer is ready. SEL reports which channel the held beat came from.
module rr_arb_2to1_8bits
    import rr_arb_2to1_8bits_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] IN1,
    input  logic              IN1_VALID,
    output logic              IN1_READY,
    input  logic [DATA_W-1:0] IN2,
    input  logic              IN2_VALID,
    output logic              IN2_READY,
    output logic [DATA_W-1:0] OUT,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              SEL
);

    state_t            state_q;
    state_t            state_d;
    logic              pri_q;
    logic [DATA_W-1:0] out_q;
    logic              sel_q;
    logic              accept;
    logic              grant_en;
    logic              gnt1;
    logic              gnt2;
    logic              grant;
    logic              gnt_idx;

    // The output stage can take a new beat when empty or being drained now.
    // Grants are also held off while reset is asserted so both READYs stay low.
    assign accept   = (state_q == EMPTY) || OUT_READY;
    assign grant_en = accept && RST_N;

    rr_grant_2 u_grant (
        .VALID1 (IN1_VALID),
        .VALID2 (IN2_VALID),
        .PRI    (pri_q),
        .EN     (grant_en),
        .GNT1   (gnt1),
        .GNT2   (gnt2)
    );

    assign grant   = gnt1 || gnt2;
    assign gnt_idx = gnt2 ? CH_IN2 : CH_IN1;

    // Next-state: a grant always leaves the stage FULL; a pop with no
    // replacement empties it. OUT_READY is irrelevant while EMPTY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (grant) state_d = FULL;
            end
            FULL: begin
                if (OUT_READY && !grant) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register; asynchronous reset discards any held beat at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Payload, source index and fairness pointer update only on a grant.
    // PRI resets to IN2 so IN1 wins the first contention.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_q <= '0;
            sel_q <= CH_IN1;
            pri_q <= CH_IN2;
        end else if (grant) begin
            out_q <= gnt2 ? IN2 : IN1;
            sel_q <= gnt_idx;
            pri_q <= gnt_idx;
        end
    end

    assign IN1_READY = gnt1;
    assign IN2_READY = gnt2;
    assign OUT       = out_q;
    assign SEL       = sel_q;
    assign OUT_VALID = (state_q == FULL);

endmodule

// File: doc/rr_arb_2to1_8bits.md
RR_ARB_2TO1_8BITS -- requirements
Module: rr_arb_2to1_8bits

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the payload width of IN1, IN2 and OUT.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port IN1, input, DATA_W bits: channel-1 payload.
REQ-005 The block SHALL have port IN1_VALID, input, 1 bit: channel-1 payload valid.
REQ-006 The block SHALL have port IN1_READY, output, 1 bit: channel-1 beat accepted this cycle.
REQ-007 The block SHALL have port IN2, input, DATA_W bits: channel-2 payload.
REQ-008 The block SHALL have port IN2_VALID, input, 1 bit: channel-2 payload valid.
REQ-009 The block SHALL have port IN2_READY, output, 1 bit: channel-2 beat accepted this cycle.
REQ-010 The block SHALL have port OUT, output, DATA_W bits: registered merged payload.
REQ-011 The block SHALL have port OUT_VALID, output, 1 bit: OUT holds a valid beat.
REQ-012 The block SHALL have port OUT_READY, input, 1 bit: the downstream consumer takes OUT this cycle.
REQ-013 The block SHALL have port SEL, output, 1 bit: source of the beat in OUT (0 = IN1, 1 = IN2), in the same encoding as the downstream 2:1 8-bit mux select.

Function
REQ-014 The block SHALL implement a two-state FSM: EMPTY (OUT_VALID = 0) and FULL (OUT_VALID = 1).
REQ-015 The block SHALL define the accept condition as ACCEPT = (state == EMPTY) or OUT_READY.
REQ-016 When only one channel is valid and ACCEPT is high, the block SHALL grant that channel.
REQ-017 When both channels are valid and ACCEPT is high, the block SHALL grant the channel opposite to the priority pointer PRI's last grant (round-robin).
REQ-018 The block SHALL assert at most one of IN1_READY or IN2_READY per cycle; INx_READY = ACCEPT and grant-to-x, combinational from the VALIDs, state and OUT_READY.
REQ-019 On a grant, the block SHALL load OUT with the granted payload, SEL with the granted index and PRI with the granted index, and SHALL enter FULL at the next edge: latency 1 cycle.
REQ-020 In FULL with OUT_READY = 0, the block SHALL hold OUT, SEL and OUT_VALID stable and drive both READYs low.
REQ-021 In FULL with OUT_READY = 1 and a valid input, the block SHALL pop and load in the same cycle and stay FULL, sustaining 1 beat/cycle.
REQ-022 In FULL with OUT_READY = 1 and no valid input, the block SHALL go to EMPTY; OUT and SEL keep their last values.
REQ-023 In EMPTY, the block SHALL ignore OUT_READY.
REQ-024 PRI SHALL change only on a grant; idle cycles SHALL NOT alter fairness.
REQ-025 With both channels continuously valid and OUT_READY = 1, the output order SHALL alternate strictly: IN1, IN2, IN1, ...
REQ-026 The block SHALL drop no beat and duplicate no beat; each accepted beat SHALL appear on OUT exactly once.

Reset
REQ-027 While RST_N = 0, the block SHALL hold OUT = 0, SEL = 0, OUT_VALID = 0, state = EMPTY and PRI = 1 (so IN1 wins the first contention), and SHALL drive both READYs 0.
REQ-028 Reset asserted mid-transfer SHALL discard the held beat immediately, without waiting for a clock edge.
REQ-029 After reset deassertion, the first grant SHALL be possible on the first rising edge.

Structure
REQ-030 The shared package SHALL hold the FSM state enum (EMPTY, FULL), the DATA_W default of 8, and the channel-index constants CH_IN1 = 0 and CH_IN2 = 1.
REQ-031 The grant logic SHALL live in one sub-module, rr_grant_2, with inputs VALID1, VALID2, PRI and EN and outputs GNT1 and GNT2; the datapath and FSM SHALL stay in the top module.

Verification
REQ-032 Reset check: assert RST_N = 0 with both VALIDs high -> OUT = 0x00, SEL = 0, OUT_VALID = 0 and both READYs 0.
REQ-033 Single channel: IN1 = 0x01 valid for one cycle, OUT_READY = 1 -> next cycle OUT = 0x01, SEL = 0, OUT_VALID = 1; the following cycle OUT_VALID = 0.
REQ-034 Contention: IN1 = 0x01 and IN2 = 0x02 both held valid, OUT_READY = 1 -> OUT sequence 0x01, 0x02, 0x01, 0x02 with SEL sequence 0, 1, 0, 1.
REQ-035 Backpressure: FULL with OUT = 0xA5 and OUT_READY = 0 for 5 cycles -> OUT stays 0xA5 and both READYs stay 0; on OUT_READY = 1, the next queued beat loads in the same cycle.
REQ-036 Reset mid-stream: drop RST_N asynchronously between edges while FULL -> OUT_VALID falls immediately, and after release IN1 wins the first contention.
REQ-037 Randomized VALID/READY over 1000 cycles -> a scoreboard confirms no beat is lost or duplicated and no channel waits more than 1 grant while the other is served.
